// File: rtl/latrsnq_bank.sv
// Bank of independent clocked set/clear/load channels. Each channel can run in
// registered or latch-emulating output mode, and set/clear collisions are counted.
module latrsnq_bank #(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] RESET_VAL    = '0,
    parameter bit               SET_DOMINANT = 1'b0,
    parameter bit               TRANSPARENT  = 1'b0,
    parameter int               CNT_WIDTH    = 4
) (
    input  logic                 CLK,
    input  logic                 RN,
    input  logic [WIDTH-1:0]     E,
    input  logic [WIDTH-1:0]     D,
    input  logic [WIDTH-1:0]     SETN,
    input  logic [WIDTH-1:0]     CLRN,
    output logic [WIDTH-1:0]     Q,
    output logic                 CONFLICT,
    output logic [CNT_WIDTH-1:0] CONFLICT_CNT
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [WIDTH-1:0]     s_reg;
    logic [WIDTH-1:0]     s_next;
    logic [WIDTH-1:0]     conflict_vec;
    logic                 conflict_cycle;
    logic                 conflict_reg;
    logic [CNT_WIDTH-1:0] cnt_reg;
    logic [CNT_WIDTH-1:0] cnt_next;

    // Per-channel next state; reset, then collision, clear, set, load, hold.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chan
            assign conflict_vec[gi] = ~SETN[gi] & ~CLRN[gi];
            assign s_next[gi] = !RN              ? RESET_VAL[gi] :
                                conflict_vec[gi] ? SET_DOMINANT  :
                                !CLRN[gi]        ? 1'b0          :
                                !SETN[gi]        ? 1'b1          :
                                E[gi]            ? D[gi]         :
                                                   s_reg[gi];
        end
    endgenerate

    // A collision during reset is swallowed by the reset itself.
    assign conflict_cycle = RN & (|conflict_vec);

    always_comb begin
        cnt_next = cnt_reg;
        if (conflict_cycle && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RN) begin
            s_reg        <= RESET_VAL;
            conflict_reg <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            s_reg        <= s_next;
            conflict_reg <= conflict_cycle;
            cnt_reg      <= cnt_next;
        end
    end

    // Flow-through mode exposes the next state; it never feeds back into s_next.
    generate
        if (TRANSPARENT) begin : g_flow
            assign Q = s_next;
        end else begin : g_reg
            assign Q = s_reg;
        end
    endgenerate

    assign CONFLICT     = conflict_reg;
    assign CONFLICT_CNT = cnt_reg;

endmodule

// File: doc/latrsnq_bank.md
# latrsnq_bank

Parametrised, clocked successor to the single-bit set/reset latch cell. It holds `WIDTH` independent channels, each with its own enable, active-low set and active-low clear. A build-time mode selects either registered output or latch-emulating flow-through output. The bank also tracks set/clear conflicts in a saturating counter. It sits wherever a group of latch-style control/status bits must be made synchronous to one clock domain for STA-clean integration.

## Interface
- `WIDTH`, 8: number of channels (1..64).
- `RESET_VAL`, all zeros (`WIDTH` bits): per-channel state loaded on reset.
- `SET_DOMINANT`, 0: conflict resolution; 0 = clear wins, 1 = set wins.
- `TRANSPARENT`, 0: output mode; 0 = `Q` registered, 1 = `Q` is the combinational next-state (latch emulation).
- `CNT_WIDTH`, 4: width of the conflict counter (2..16).

Ports:
- `CLK`  in  1  clock; all state updates on rising edge.
- `RN`  in  1  reset; synchronous, active-low.
- `E`  in  `WIDTH`  per-channel load enable, active-high.
- `D`  in  `WIDTH`  per-channel data.
- `SETN`  in  `WIDTH`  per-channel set, active-low.
- `CLRN`  in  `WIDTH`  per-channel clear, active-low.
- `Q`  out  `WIDTH`  channel outputs.
- `CONFLICT`  out  1  registered flag: a set/clear conflict occurred in the previous cycle.
- `CONFLICT_CNT`  out  `CNT_WIDTH`  saturating count of conflict cycles.

## Operation
- Internal state `S[WIDTH]`. The per-channel next-state `N[i]` is decided in this priority order:
  1. `RN`=0 → `RESET_VAL[i]`.
  2. `SETN[i]`=0 and `CLRN[i]`=0 → `SET_DOMINANT`.
  3. `CLRN[i]`=0 → 0.
  4. `SETN[i]`=0 → 1.
  5. `E[i]`=1 → `D[i]`.
  6. Otherwise → `S[i]` (hold).
- `S` loads `N` on every rising edge of `CLK`.
- `TRANSPARENT`=0: `Q = S`.
- `TRANSPARENT`=1: `Q = N`, purely combinational from the inputs and `S`. There is no combinational path from `Q` back into `N`.
- Conflict cycle: `RN`=1 and at least one channel has `SETN[i]`=0 and `CLRN[i]`=0 in the same cycle.
- `CONFLICT` registers 1 after a conflict cycle and 0 otherwise. It asserts for exactly one cycle per conflict cycle; consecutive conflict cycles keep it high.
- `CONFLICT_CNT` increments by 1 per conflict cycle, independent of how many channels conflict. It saturates at 2^`CNT_WIDTH`−1 and never wraps. Only `RN` clears it.
- Channels are fully independent. Behaviour for channels with no conflict is unaffected by a conflict on any other channel.

## Timing
- Reset values after the first rising edge with `RN`=0:
  - `S = RESET_VAL`.
  - `Q = RESET_VAL` in both modes. With `TRANSPARENT`=1, `Q` already equals `RESET_VAL` combinationally while `RN`=0.
  - `CONFLICT = 0`, `CONFLICT_CNT = 0`.
- Latency, `TRANSPARENT`=0: an input change is visible on `Q` one cycle later.
- Latency, `TRANSPARENT`=1: an input change is visible on `Q` in the same cycle and is held from the next edge onward.
- `CONFLICT` and `CONFLICT_CNT` always lag the conflict cycle by exactly one edge.
- Reset mid-operation: `RN`=0 overrides set, clear, enable and conflict counting in that cycle. A conflict in a reset cycle is not counted.
- Before the first reset, the state is undefined (X in simulation). No power-on value is guaranteed.
- `E`, `D`, `SETN` and `CLRN` have no effect on `S` or the counter between clock edges.

## Test plan
- Reset: `WIDTH`=8, `RESET_VAL`=8'hA5, hold `RN`=0 for 2 cycles → `Q`=8'hA5, `CONFLICT`=0, `CONFLICT_CNT`=0. Release `RN` with all `E`=0 → `Q` stays 8'hA5.
- Load/hold, `TRANSPARENT`=0: `E`=8'h0F, `D`=8'h3C for one cycle → next cycle `Q`=8'hAC (low nibble loaded, high nibble held). Drop `E` and change `D` → `Q` unchanged.
- Set/clear priority: `SETN[0]`=0 and `CLRN[1]`=0 with `E`=8'hFF, `D`=8'h02 → `Q[0]`=1, `Q[1]`=0, all other bits follow `D`.
- Conflict, `SET_DOMINANT`=0 then 1: `SETN[3]`=`CLRN[3]`=0 for 3 consecutive cycles → `Q[3]`=0 (respectively 1), `CONFLICT` high for 3 cycles starting one edge later, `CONFLICT_CNT`=3.
- Saturation: `CNT_WIDTH`=2, apply 6 conflict cycles → `CONFLICT_CNT` reads 1, 2, 3, 3, 3, 3. Assert `RN`=0 during a conflict cycle → count returns to 0 and does not increment.
- Transparent mode: `TRANSPARENT`=1, `E[2]`=1, toggle `D[2]` mid-cycle → `Q[2]` follows within the same cycle. Drop `E[2]` → `Q[2]` holds the last value sampled at the edge.
